// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : Oversampled UART receiver with majority sampling, parity, 1/2 stop
//            bits, false-start rejection and break detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_TICK,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_ODD,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  FRM_ERR,
    output logic                  BREAK_DET,
    output logic                  BUSY
);

    localparam int c_CW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_WIDTH);
    localparam int c_M  = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_STOP_2   = 3'd5,
        S_BRK_WAIT = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [c_BW-1:0]       r_bitcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_sync1, r_sync2;
    logic                  r_s0, r_s1;
    logic                  r_par_en, r_par_odd, r_stop2;
    logic                  r_par_err, r_par_bit, r_stop_bad;

    logic w_rxs, w_maj, w_mid, w_end, w_final, w_stop_bad, w_brk;

    assign w_rxs      = r_sync2;
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_mid      = (r_cnt == c_CW'(c_M + 1));
    assign w_end      = (r_cnt == c_CW'(OVERSAMPLE - 1));
    // Last stop bit is resolved mid-bit, leaving half a bit of resync margin
    assign w_final    = w_mid && (((r_state == S_STOP) && !r_stop2) || (r_state == S_STOP_2));
    assign w_stop_bad = r_stop_bad | ~w_maj;
    assign w_brk      = w_stop_bad && (r_shift == '0) && !(r_par_en && r_par_bit);
    assign BUSY       = (r_state != S_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_par_err  <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_bad <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            FRM_ERR    <= 1'b0;
            BREAK_DET  <= 1'b0;
        end else begin
            r_sync1    <= RX_IN;
            r_sync2    <= r_sync1;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            FRM_ERR    <= 1'b0;
            BREAK_DET  <= 1'b0;
            if (RX_TICK) begin
                if (r_state != S_IDLE && r_state != S_BRK_WAIT) begin
                    r_cnt <= w_end ? '0 : r_cnt + 1'b1;
                    if (r_cnt == c_CW'(c_M - 1)) r_s0 <= w_rxs;
                    if (r_cnt == c_CW'(c_M))     r_s1 <= w_rxs;
                end
                case (r_state)
                    S_IDLE: begin
                        if (!w_rxs) begin
                            r_state    <= S_START;
                            r_cnt      <= c_CW'(1);
                            r_bitcnt   <= '0;
                            r_par_en   <= PAR_EN;
                            r_par_odd  <= PAR_ODD;
                            r_stop2    <= STOP2;
                            r_par_err  <= 1'b0;
                            r_par_bit  <= 1'b0;
                            r_stop_bad <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (w_mid && w_maj) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else if (w_end) begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_mid) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                        if (w_end) begin
                            if (r_bitcnt == c_BW'(DATA_WIDTH - 1)) begin
                                r_bitcnt <= '0;
                                r_state  <= r_par_en ? S_PARITY : S_STOP;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_mid) begin
                            r_par_bit <= w_maj;
                            r_par_err <= ((^r_shift) ^ w_maj) != r_par_odd;
                        end else if (w_end) begin
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_mid && r_stop2) r_stop_bad <= ~w_maj;
                        if (w_end && r_stop2) r_state <= S_STOP_2;
                    end
                    S_STOP_2: begin
                    end
                    S_BRK_WAIT: begin
                        if (w_rxs) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
                if (w_final) begin
                    r_cnt <= '0;
                    if (w_brk) begin
                        BREAK_DET <= 1'b1;
                        FRM_ERR   <= 1'b1;
                        r_state   <= S_BRK_WAIT;
                    end else if (w_stop_bad) begin
                        FRM_ERR <= 1'b1;
                        PAR_ERR <= r_par_err;
                        r_state <= S_IDLE;
                    end else if (r_par_err) begin
                        PAR_ERR <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        P_DATA     <= r_shift;
                        DATA_VALID <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Scoreboard bench for uart_rx_ctrl (8-bit and 7-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int OS = 16;

    typedef struct packed {
        logic [3:0]        f;   // {valid, par_err, frm_err, break}
        logic [8:0]        d;
        logic signed [31:0] t;  // expected tick index, -1 = don't care
    } exp_t;

    logic CLK = 1'b0, RST = 1'b0, RX_TICK = 1'b0;
    logic rx8 = 1'b1, rx7 = 1'b1;
    logic PAR_EN = 1'b0, PAR_ODD = 1'b0, STOP2 = 1'b0;
    logic [7:0] pd8;
    logic [6:0] pd7;
    logic dv8, pe8, fe8, bk8, busy8;
    logic dv7, pe7, fe7, bk7, busy7;

    int   n_checks = 0;
    int   n_err    = 0;
    int   tick_idx = 0;
    logic prev_tick = 1'b0;
    exp_t q8[$];
    exp_t q7[$];

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) u_dut8 (
        .CLK(CLK), .RST(RST), .RX_TICK(RX_TICK), .RX_IN(rx8),
        .PAR_EN(PAR_EN), .PAR_ODD(PAR_ODD), .STOP2(STOP2),
        .P_DATA(pd8), .DATA_VALID(dv8), .PAR_ERR(pe8), .FRM_ERR(fe8),
        .BREAK_DET(bk8), .BUSY(busy8)
    );

    uart_rx_ctrl #(.DATA_WIDTH(7), .OVERSAMPLE(OS)) u_dut7 (
        .CLK(CLK), .RST(RST), .RX_TICK(RX_TICK), .RX_IN(rx7),
        .PAR_EN(PAR_EN), .PAR_ODD(PAR_ODD), .STOP2(STOP2),
        .P_DATA(pd7), .DATA_VALID(dv7), .PAR_ERR(pe7), .FRM_ERR(fe7),
        .BREAK_DET(bk7), .BUSY(busy7)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) prev_tick <= RX_TICK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [3:0] f, input logic [8:0] dat, input int t);
        exp_t e;
        e.f = f;
        e.d = dat;
        e.t = 32'(t);
        if (d == 8) q8.push_back(e);
        else        q7.push_back(e);
    endtask

    task automatic score(input int d, input logic [3:0] f, input logic [8:0] dat);
        exp_t e;
        if ((d == 8 ? q8.size() : q7.size()) == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pulse dut%0d: flags %b data %0h, nothing expected", d, f, dat);
        end else begin
            e = (d == 8) ? q8.pop_front() : q7.pop_front();
            check($sformatf("flags_dut%0d", d), 32'(f), 32'(e.f));
            check($sformatf("p_data_dut%0d", d), 32'(dat), 32'(e.d));
            if (e.t >= 0) begin
                check("latency_tick", 32'(tick_idx), 32'(e.t));
                check("latency_edge", 32'(prev_tick), 32'(1));
            end
        end
    endtask

    // Monitor: any pulse output pops one expectation
    always @(negedge CLK) begin
        if (RST && (dv8 | pe8 | fe8 | bk8)) score(8, {dv8, pe8, fe8, bk8}, {1'b0, pd8});
        if (RST && (dv7 | pe7 | fe7 | bk7)) score(7, {dv7, pe7, fe7, bk7}, {2'b0, pd7});
    end

    task automatic do_tick();
        repeat (3) @(negedge CLK);
        RX_TICK = 1'b1;
        tick_idx++;
        @(negedge CLK);
        RX_TICK = 1'b0;
    endtask

    task automatic send_bit(input int d, input logic b, input int nt);
        if (d == 8) rx8 = b;
        else        rx7 = b;
        repeat (nt) do_tick();
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                              input logic pen, input logic pbit, input logic s1,
                              input logic s2en, input logic s2);
        send_bit(d, 1'b0, OS);
        for (int i = 0; i < nbits; i++) send_bit(d, data[i], OS);
        if (pen) send_bit(d, pbit, OS);
        if (s2en) begin
            send_bit(d, s1, OS);
            send_bit(d, s2, s2 ? OS : 10);
        end else begin
            send_bit(d, s1, s1 ? OS : 10);
        end
        send_bit(d, 1'b1, 2 * OS);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        check("reset_p_data", 32'(pd8), 32'(0));
        check("reset_pulses", 32'({dv8, pe8, fe8, bk8}), 32'(0));
        check("reset_busy", 32'(busy8), 32'(0));
        @(negedge CLK);
        RST = 1'b1;
        send_bit(8, 1'b1, 8);

        // 8N1 0xA5 with latency check: tick 153 of the frame
        push(8, 4'b1000, 9'h0A5, tick_idx + 1 + 153);
        send_frame(8, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("busy_after_frame", 32'(busy8), 32'(0));

        // 8E1 0x3C, wrong then correct parity
        PAR_EN = 1'b1; PAR_ODD = 1'b0;
        push(8, 4'b0100, 9'h0A5, -1);
        send_frame(8, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        push(8, 4'b1000, 9'h03C, -1);
        send_frame(8, 9'h03C, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Glitch shorter than half a bit, then 8N1 0x55
        PAR_EN = 1'b0;
        send_bit(8, 1'b0, 5);
        send_bit(8, 1'b1, 30);
        check("busy_after_glitch", 32'(busy8), 32'(0));
        push(8, 4'b1000, 9'h055, -1);
        send_frame(8, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // 7O2 0x41: bad second stop, then good
        PAR_EN = 1'b1; PAR_ODD = 1'b1; STOP2 = 1'b1;
        push(7, 4'b0010, 9'h000, -1);
        send_frame(7, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(7, 4'b1000, 9'h041, -1);
        send_frame(7, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Break: line low for 20 bit times
        PAR_EN = 1'b0; PAR_ODD = 1'b0; STOP2 = 1'b0;
        push(8, 4'b0011, 9'h055, -1);
        send_bit(8, 1'b0, 10 * OS);
        check("busy_in_break", 32'(busy8), 32'(1));
        send_bit(8, 1'b0, 10 * OS);
        check("busy_brk_wait", 32'(busy8), 32'(1));
        send_bit(8, 1'b1, OS);
        check("busy_after_break", 32'(busy8), 32'(0));
        push(8, 4'b1000, 9'h00F, -1);
        send_frame(8, 9'h00F, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of the data bits
        send_bit(8, 1'b0, OS);
        send_bit(8, 1'b1, 3 * OS);
        check("busy_mid_data", 32'(busy8), 32'(1));
        RST = 1'b0;
        #1;
        check("rst_mid_p_data8", 32'(pd8), 32'(0));
        check("rst_mid_p_data7", 32'(pd7), 32'(0));
        check("rst_mid_pulses", 32'({dv8, pe8, fe8, bk8}), 32'(0));
        check("rst_mid_busy", 32'(busy8), 32'(0));
        rx8 = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        send_bit(8, 1'b1, OS);
        push(8, 4'b1000, 9'h081, -1);
        send_frame(8, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        send_bit(8, 1'b1, OS);
        check("pending_dut8", 32'(q8.size()), 32'(0));
        check("pending_dut7", 32'(q7.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
